// File: rtl/p_hardisc.sv
// rtl/p_hardisc.sv - shared AHB constants, responder FSM type, parity and SEC-DED helpers
package p_hardisc;

    localparam logic [1:0] AHB_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] AHB_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] AHB_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] AHB_HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        RESP_IDLE,
        RESP_DATA,
        RESP_ERR1,
        RESP_ERR2
    } resp_fsm_t;

    // Even parity per group: [3:0] address bytes, [4] control, [5] htrans.
    function automatic logic [5:0] ahb_parity(
        input logic [31:0] addr,
        input logic [1:0]  trans,
        input logic        write,
        input logic [2:0]  size,
        input logic [2:0]  burst,
        input logic [3:0]  prot,
        input logic        lock
    );
        ahb_parity = {^trans, ^{write, size, burst, prot, lock},
                      ^addr[31:24], ^addr[23:16], ^addr[15:8], ^addr[7:0]};
    endfunction

    // Hamming check bits: data fills non-power-of-two positions 3..38, bit 6 is overall parity.
    function automatic logic [6:0] secded_check(input logic [31:0] data);
        logic [6:0] chk;
        logic [5:0] pos6;
        int         d;
        chk = '0;
        d   = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                pos6 = pos[5:0];
                if (data[d[4:0]]) begin
                    chk[5:0] = chk[5:0] ^ pos6;
                end
                d++;
            end
        end
        chk[6] = (^data) ^ (^chk[5:0]);
        return chk;
    endfunction

endpackage

// File: rtl/tcm_secded_enc.sv
// rtl/tcm_secded_enc.sv - 32-bit to 7 check-bit SEC-DED encoder
module tcm_secded_enc
    import p_hardisc::*;
(
    input  logic [31:0] data,
    output logic [6:0]  check
);

    assign check = secded_check(data);

endmodule

// File: rtl/ahb_tcm_responder.sv
// rtl/ahb_tcm_responder.sv - AHB-Lite TCM subordinate with parity/checksum protection
module ahb_tcm_responder
    import p_hardisc::*;
#(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_hsel_i,
    input  logic [31:0] s_haddr_i,
    input  logic [1:0]  s_htrans_i,
    input  logic        s_hwrite_i,
    input  logic [2:0]  s_hsize_i,
    input  logic [2:0]  s_hburst_i,
    input  logic [3:0]  s_hprot_i,
    input  logic        s_hmastlock_i,
    input  logic [5:0]  s_hparity_i,
    input  logic [31:0] s_hwdata_i,
    input  logic [6:0]  s_hwchecksum_i,
    output logic [31:0] s_hrdata_o,
    output logic [6:0]  s_hrchecksum_o,
    output logic        s_hready_o,
    output logic        s_hresp_o,
    output logic        s_prot_err_o
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    resp_fsm_t     state_q, state_d;
    logic [AW-1:0] word_q;
    logic [1:0]    offs_q;
    logic [1:0]    size_q;
    logic          write_q;
    logic          prot_q;
    logic          first_q;
    logic [3:0]    wait_q;

    logic [31:0]   mem [MEM_WORDS];

    logic          accept;
    logic          parity_err, range_err, size_err, align_err, addr_err;
    logic          cks_err, cks_fail_now, commit, rd_valid;
    logic [6:0]    wr_check;
    logic [3:0]    lanes;

    assign parity_err = ahb_parity(s_haddr_i, s_htrans_i, s_hwrite_i, s_hsize_i,
                                   s_hburst_i, s_hprot_i, s_hmastlock_i) != s_hparity_i;
    assign range_err  = |s_haddr_i[31:AW+2];
    assign size_err   = s_hsize_i > 3'd2;
    assign align_err  = ((s_hsize_i == 3'd1) && s_haddr_i[0]) ||
                        ((s_hsize_i == 3'd2) && (|s_haddr_i[1:0]));
    assign addr_err   = parity_err | range_err | size_err | align_err;

    tcm_secded_enc u_wr_enc (
        .data  (s_hwdata_i),
        .check (wr_check)
    );

    assign cks_err      = wr_check != s_hwchecksum_i;
    assign cks_fail_now = (state_q == RESP_DATA) && first_q && write_q && cks_err;

    always_comb begin
        state_d      = state_q;
        s_hready_o   = 1'b1;
        s_hresp_o    = 1'b0;
        s_prot_err_o = 1'b0;
        accept       = 1'b0;
        case (state_q)
            RESP_DATA: begin
                if (cks_fail_now) begin
                    s_hready_o = 1'b0;
                    state_d    = RESP_ERR1;
                end else if (wait_q != '0) begin
                    s_hready_o = 1'b0;
                end else begin
                    state_d = RESP_IDLE;
                end
            end
            RESP_ERR1: begin
                s_hready_o   = 1'b0;
                s_hresp_o    = 1'b1;
                s_prot_err_o = prot_q;
                state_d      = RESP_ERR2;
            end
            RESP_ERR2: begin
                s_hresp_o = 1'b1;
                state_d   = RESP_IDLE;
            end
            default: ;
        endcase
        // Sampling edges are exactly those where hready is high, so back-to-back needs no extra state.
        accept = s_hready_o & s_hsel_i & s_htrans_i[1];
        if (accept) begin
            state_d = addr_err ? RESP_ERR1 : RESP_DATA;
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state_q <= RESP_IDLE;
            word_q  <= '0;
            offs_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            prot_q  <= 1'b0;
            first_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            first_q <= 1'b0;
            if (state_q == RESP_DATA && wait_q != '0) begin
                wait_q <= wait_q - 4'd1;
            end
            if (cks_fail_now) begin
                prot_q <= 1'b1;
            end
            if (accept) begin
                word_q  <= s_haddr_i[AW+1:2];
                offs_q  <= s_haddr_i[1:0];
                size_q  <= s_hsize_i[1:0];
                write_q <= s_hwrite_i;
                prot_q  <= parity_err;
                first_q <= ~addr_err;
                if (!addr_err) begin
                    wait_q <= WAIT_INIT;
                end
            end
        end
    end

    always_comb begin
        case (size_q)
            2'd0:    lanes = 4'b0001 << offs_q;
            2'd1:    lanes = 4'b0011 << offs_q;
            default: lanes = 4'b1111;
        endcase
    end

    assign commit = (state_q == RESP_DATA) && s_hready_o && write_q;

    always_ff @(posedge s_clk_i) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes[b]) begin
                    mem[word_q][8*b +: 8] <= s_hwdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read data comes straight from the array so a write committing on this read's sample edge is seen.
    assign rd_valid   = (state_q == RESP_DATA) && !write_q;
    assign s_hrdata_o = rd_valid ? mem[word_q] : '0;

    tcm_secded_enc u_rd_enc (
        .data  (s_hrdata_o),
        .check (s_hrchecksum_o)
    );

endmodule

// File: tb/tb_ahb_tcm_responder.sv
// tb/tb_ahb_tcm_responder.sv - directed bench with cycle-level response model for ahb_tcm_responder
module tb_ahb_tcm_responder;

    localparam int MW = 1024;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn0, rstn1, use_w3;
    logic        hsel, hsel0, hsel1, hwrite, hmastlock;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [5:0]  hparity;
    logic [6:0]  hwchk;

    logic [31:0] rdata0, rdata1, rdata;
    logic [6:0]  rchk0, rchk1, rchk;
    logic        rdy0, rdy1, rdy, resp0, resp1, resp, perr0, perr1, perr;

    assign hsel0 = hsel & ~use_w3;
    assign hsel1 = hsel & use_w3;
    assign rdata = use_w3 ? rdata1 : rdata0;
    assign rchk  = use_w3 ? rchk1  : rchk0;
    assign rdy   = use_w3 ? rdy1   : rdy0;
    assign resp  = use_w3 ? resp1  : resp0;
    assign perr  = use_w3 ? perr1  : perr0;

    ahb_tcm_responder #(.MEM_WORDS(MW), .WAIT_STATES(0)) u_dut0 (
        .s_clk_i(clk), .s_resetn_i(rstn0), .s_hsel_i(hsel0), .s_haddr_i(haddr),
        .s_htrans_i(htrans), .s_hwrite_i(hwrite), .s_hsize_i(hsize), .s_hburst_i(hburst),
        .s_hprot_i(hprot), .s_hmastlock_i(hmastlock), .s_hparity_i(hparity),
        .s_hwdata_i(hwdata), .s_hwchecksum_i(hwchk), .s_hrdata_o(rdata0),
        .s_hrchecksum_o(rchk0), .s_hready_o(rdy0), .s_hresp_o(resp0), .s_prot_err_o(perr0)
    );

    ahb_tcm_responder #(.MEM_WORDS(MW), .WAIT_STATES(3)) u_dut1 (
        .s_clk_i(clk), .s_resetn_i(rstn1), .s_hsel_i(hsel1), .s_haddr_i(haddr),
        .s_htrans_i(htrans), .s_hwrite_i(hwrite), .s_hsize_i(hsize), .s_hburst_i(hburst),
        .s_hprot_i(hprot), .s_hmastlock_i(hmastlock), .s_hparity_i(hparity),
        .s_hwdata_i(hwdata), .s_hwchecksum_i(hwchk), .s_hrdata_o(rdata1),
        .s_hrchecksum_o(rchk1), .s_hready_o(rdy1), .s_hresp_o(resp1), .s_prot_err_o(perr1)
    );

    typedef struct {
        bit          rdy;
        bit          resp;
        bit          perr;
        bit          has_data;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [31:0] mmem [int];
    int          total = 0;
    int          bad   = 0;
    logic        rdy_seen = 1'b0;

    function automatic exp_t mk(input bit r, input bit s, input bit p, input bit h, input logic [31:0] d);
        exp_t e;
        e.rdy = r; e.resp = s; e.perr = p; e.has_data = h; e.data = d;
        return e;
    endfunction

    // Build the 38-bit Hamming codeword explicitly, then take each check bit over its position class.
    function automatic logic [6:0] ref_enc(input logic [31:0] d);
        logic [38:0] cw;
        logic [6:0]  c;
        int          k;
        cw = '0;
        k  = 0;
        for (int p = 1; p < 39; p++) begin
            if (p != 1 && p != 2 && p != 4 && p != 8 && p != 16 && p != 32) begin
                cw[p] = d[k];
                k++;
            end
        end
        c = '0;
        for (int i = 0; i < 6; i++) begin
            for (int p = 1; p < 39; p++) begin
                if (((p >> i) & 1) == 1) c[i] = c[i] ^ cw[p];
            end
        end
        c[6] = (^d) ^ (^c[5:0]);
        return c;
    endfunction

    function automatic logic [5:0] good_parity(input logic [31:0] a, input logic [1:0] tr, input logic wr,
                                               input logic [2:0] sz, input logic [2:0] bu,
                                               input logic [3:0] pr, input logic lk);
        logic [5:0] p;
        for (int b = 0; b < 4; b++) p[b] = ^a[8*b +: 8];
        p[4] = ^{wr, sz, bu, pr, lk};
        p[5] = ^tr;
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) cur = q.pop_front();
        else              cur = mk(1, 0, 0, 0, 32'h0);
        chk("hready", {31'b0, rdy}, {31'b0, cur.rdy});
        chk("hresp", {31'b0, resp}, {31'b0, cur.resp});
        chk("prot_err", {31'b0, perr}, {31'b0, cur.perr});
        if (cur.has_data) begin
            chk("hrdata", rdata, cur.data);
            chk("hrchecksum", {25'b0, rchk}, {25'b0, ref_enc(cur.data)});
        end
        rdy_seen = rdy;
    end

    task automatic model_push(input logic [31:0] a, input bit wr, input logic [2:0] sz,
                              input logic [31:0] wd, input logic [5:0] pflip, input logic [6:0] cflip);
        bit          par_bad, addr_bad;
        int          key, ws, lo;
        logic [31:0] w;
        par_bad  = pflip != 0;
        addr_bad = par_bad || (a >= 32'(4 * MW)) || (sz > 3'd2) ||
                   ((sz <= 3'd2) && ((a % (32'd1 << sz)) != 0));
        ws  = use_w3 ? 3 : 0;
        key = (use_w3 ? 65536 : 0) + int'(a / 4);
        if (addr_bad) begin
            q.push_back(mk(0, 1, par_bad, 0, 0));
            q.push_back(mk(1, 1, 0, 0, 0));
        end else if (wr && cflip != 0) begin
            q.push_back(mk(0, 0, 0, 0, 0));
            q.push_back(mk(0, 1, 1, 0, 0));
            q.push_back(mk(1, 1, 0, 0, 0));
        end else begin
            repeat (ws) q.push_back(mk(0, 0, 0, 0, 0));
            if (wr) begin
                w  = mmem.exists(key) ? mmem[key] : 32'hx;
                lo = int'(a % 4);
                for (int b = lo; b < lo + (1 << sz); b++) w[8*b +: 8] = wd[8*b +: 8];
                mmem[key] = w;
                q.push_back(mk(1, 0, 0, 0, 0));
            end else if (mmem.exists(key)) begin
                q.push_back(mk(1, 0, 0, 1, mmem[key]));
            end else begin
                q.push_back(mk(1, 0, 0, 0, 0));
            end
        end
    endtask

    // Drive an address phase, wait for it to be sampled, then drive its data-phase write bus.
    task automatic xfer(input logic [31:0] a, input bit wr, input logic [2:0] sz, input logic [31:0] wd,
                        input logic [5:0] pflip, input logic [6:0] cflip);
        int n;
        haddr = a; hwrite = wr; hsize = sz; htrans = 2'b10; hsel = 1'b1;
        hburst = 3'b001; hprot = 4'b0011; hmastlock = 1'b0;
        hparity = good_parity(a, 2'b10, wr, sz, 3'b001, 4'b0011, 1'b0) ^ pflip;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!rdy_seen && n < 50);
        if (!rdy_seen) begin
            total++; bad++;
            $display("FAIL accept_timeout: addr %h not sampled within %0d cycles", a, n);
        end
        model_push(a, wr, sz, wd, pflip, cflip);
        #1;
        hsel = 1'b0; htrans = 2'b00;
        hwdata = wd; hwchk = ref_enc(wd) ^ cflip;
    endtask

    task automatic lit_read(input string name, input logic [31:0] exp);
        @(negedge clk);
        chk(name, rdata, exp);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_queue_empty", q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int lows;
        rstn0 = 1'b1; rstn1 = 1'b1; use_w3 = 1'b0;
        hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2;
        hburst = '0; hprot = '0; hmastlock = 1'b0; hparity = '0; hwdata = '0; hwchk = '0;
        #1;
        rstn0 = 1'b0; rstn1 = 1'b0;
        #2;
        chk("rst_hready", {31'b0, rdy0}, 32'd1);
        chk("rst_hresp", {31'b0, resp0}, 32'd0);
        chk("rst_hrdata", rdata0, 32'h0);
        chk("rst_hrchecksum", {25'b0, rchk0}, 32'h0);
        chk("rst_prot_err", {31'b0, perr1}, 32'd0);
        chk("enc_0", {25'b0, ref_enc(32'h0)}, 32'h00);
        chk("enc_1", {25'b0, ref_enc(32'h1)}, 32'h43);
        chk("enc_2", {25'b0, ref_enc(32'h2)}, 32'h45);
        chk("enc_msb", {25'b0, ref_enc(32'h8000_0000)}, 32'h26);
        repeat (2) @(posedge clk);
        #1;
        rstn0 = 1'b1; rstn1 = 1'b1;

        // word write then back-to-back read
        xfer(32'h10, 1, 3'd2, 32'hDEADBEEF, 6'h0, 7'h0);
        xfer(32'h10, 0, 3'd2, 32'h0, 6'h0, 7'h0);
        lit_read("b2b_read_deadbeef", 32'hDEADBEEF);

        // byte lane 1 write over a zero word
        xfer(32'h10, 1, 3'd2, 32'h0000_0000, 6'h0, 7'h0);
        xfer(32'h11, 1, 3'd0, 32'h0000_AA00, 6'h0, 7'h0);
        xfer(32'h10, 0, 3'd2, 32'h0, 6'h0, 7'h0);
        lit_read("byte_write_read", 32'h0000_AA00);

        // address parity error on a write
        xfer(32'h20, 1, 3'd2, 32'h1234_5678, 6'h0, 7'h0);
        xfer(32'h20, 1, 3'd2, 32'hFFFF_FFFF, 6'h01, 7'h0);
        @(negedge clk);
        chk("perr_err1_hready", {31'b0, rdy}, 32'd0);
        chk("perr_err1_hresp", {31'b0, resp}, 32'd1);
        chk("perr_err1_prot", {31'b0, perr}, 32'd1);
        @(negedge clk);
        chk("perr_err2_hready", {31'b0, rdy}, 32'd1);
        chk("perr_err2_hresp", {31'b0, resp}, 32'd1);
        @(posedge clk); #1;
        xfer(32'h20, 0, 3'd2, 32'h0, 6'h0, 7'h0);
        lit_read("perr_mem_kept", 32'h1234_5678);

        // write checksum error
        xfer(32'h30, 1, 3'd2, 32'h55AA_55AA, 6'h0, 7'h0);
        xfer(32'h30, 1, 3'd2, 32'h1111_1111, 6'h0, 7'h08);
        @(negedge clk);
        chk("cks_data_hresp", {31'b0, resp}, 32'd0);
        @(negedge clk);
        chk("cks_err1_prot", {31'b0, perr}, 32'd1);
        @(posedge clk); #1;
        xfer(32'h30, 0, 3'd2, 32'h0, 6'h0, 7'h0);
        lit_read("cks_mem_kept", 32'h55AA_55AA);

        // range and alignment errors, back to back
        xfer(32'(4 * MW), 0, 3'd2, 32'h0, 6'h0, 7'h0);
        xfer(32'h01, 0, 3'd1, 32'h0, 6'h0, 7'h0);
        xfer(32'h02, 0, 3'd3, 32'h0, 6'h0, 7'h0);
        drain();

        // three wait states
        use_w3 = 1'b1;
        xfer(32'h40, 1, 3'd2, 32'hCAFE_F00D, 6'h0, 7'h0);
        xfer(32'h40, 0, 3'd2, 32'h0, 6'h0, 7'h0);
        lows = 0;
        @(negedge clk);
        while (rdy1 == 1'b0 && lows < 20) begin
            lows++;
            @(negedge clk);
        end
        chk("w3_wait_cycles", lows, 3);
        chk("w3_rdata", rdata1, 32'hCAFE_F00D);
        @(posedge clk); #1;
        drain();

        // reset in the second wait cycle
        xfer(32'h40, 0, 3'd2, 32'h0, 6'h0, 7'h0);
        @(posedge clk);
        #2;
        rstn1 = 1'b0;
        q.delete();
        #1;
        chk("rst_mid_hready", {31'b0, rdy1}, 32'd1);
        chk("rst_mid_hresp", {31'b0, resp1}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn1 = 1'b1;
        xfer(32'h40, 0, 3'd2, 32'h0, 6'h0, 7'h0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
